// File: rtl/l2_arbiter.sv
// Serialises I-cache and D-cache line requests onto the single L2 port.
// Optional L2_ARB_RR_EN: round-robin on ties; otherwise the D-cache wins ties.
module l2_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic                  i_resp,
   output logic [LINE_WIDTH-1:0] i_rdata,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic                  d_resp,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_address,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic                  l2_resp,
   input  logic [LINE_WIDTH-1:0] l2_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t                  state_r;
   logic [LINE_WIDTH-1:0]   rdata_r;
   logic                    d_req_s;
   logic                    grant_d_s;

   assign d_req_s = d_read | d_write;
   assign i_rdata = rdata_r;
   assign d_rdata = rdata_r;

`ifdef L2_ARB_RR_EN
   logic prefer_d_r;

   // Tie-break follows the pointer; a lone requester always wins.
   always_comb begin
      if (d_req_s && i_read) begin
         grant_d_s = prefer_d_r;
      end else begin
         grant_d_s = d_req_s;
      end
   end
`else
   // D-cache wins every tie.
   always_comb begin
      grant_d_s = d_req_s;
   end
`endif

   // Arbitration FSM; all L2 and L1 response outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         i_resp     <= 1'b0;
         d_resp     <= 1'b0;
         l2_read    <= 1'b0;
         l2_write   <= 1'b0;
         l2_address <= {ADDR_WIDTH{1'b0}};
         l2_wdata   <= {LINE_WIDTH{1'b0}};
         rdata_r    <= {LINE_WIDTH{1'b0}};
`ifdef L2_ARB_RR_EN
         prefer_d_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               i_resp <= 1'b0;
               d_resp <= 1'b0;
               if (grant_d_s) begin
                  // A simultaneous read+write is issued as the writeback.
                  state_r    <= GRANT_D;
                  l2_write   <= d_write;
                  l2_read    <= ~d_write;
                  l2_address <= d_address;
                  l2_wdata   <= d_wdata;
`ifdef L2_ARB_RR_EN
                  prefer_d_r <= 1'b0;
`endif
               end else if (i_read) begin
                  state_r    <= GRANT_I;
                  l2_read    <= 1'b1;
                  l2_write   <= 1'b0;
                  l2_address <= i_address;
`ifdef L2_ARB_RR_EN
                  prefer_d_r <= 1'b1;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            GRANT_I, GRANT_D: begin
               if (l2_resp) begin
                  rdata_r  <= l2_rdata;
                  l2_read  <= 1'b0;
                  l2_write <= 1'b0;
                  i_resp   <= (state_r == GRANT_I);
                  d_resp   <= (state_r == GRANT_D);
                  state_r  <= RESP;
               end else begin
                  state_r <= state_r;
               end
            end
            RESP: begin
               i_resp  <= 1'b0;
               d_resp  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r  <= IDLE;
               i_resp   <= 1'b0;
               d_resp   <= 1'b0;
               l2_read  <= 1'b0;
               l2_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: stimulus pushes expectations, a monitor checks L2 and L1 sides.
module tb_l2_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_read = 1'b0;
   logic [31:0]  i_address = 32'h0;
   logic         i_resp;
   logic [255:0] i_rdata;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [31:0]  d_address = 32'h0;
   logic [255:0] d_wdata = 256'h0;
   logic         d_resp;
   logic [255:0] d_rdata;
   logic         l2_read;
   logic         l2_write;
   logic [31:0]  l2_address;
   logic [255:0] l2_wdata;
   logic         l2_resp = 1'b0;
   logic [255:0] l2_rdata = 256'h0;

   typedef struct {
      bit           d;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic [255:0] rdata;
      int           lat;
   } exp_t;

   exp_t         sb[$];
   int           errors = 0;
   int           checks = 0;
   int           l2_lat = 3;
   logic [255:0] l2_line = 256'h0;

   l2_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_resp(l2_resp), .l2_rdata(l2_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // L2 model: responds in the l2_lat-th cycle of a held request
   initial begin
      int cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !(l2_read || l2_write)) begin
            cnt = 0;
            l2_resp = 1'b0;
         end else begin
            cnt++;
            if (cnt == l2_lat) begin
               l2_resp = 1'b1;
               l2_rdata = l2_line;
            end else begin
               l2_resp = 1'b0;
            end
         end
      end
   end

   // Monitor: checks held L2 request each cycle and pops on each L1 response
   initial begin
      int   req_cycles = 0;
      bit   prev_resp = 1'b0;
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            req_cycles = 0;
            prev_resp = 1'b0;
            continue;
         end
         if (prev_resp) chk("resp_one_cycle", {i_resp, d_resp}, 2'b00);
         if (l2_read || l2_write) begin
            if (sb.size() == 0) begin
               chk("unexpected_l2_req", {l2_read, l2_write}, 2'b00);
            end else begin
               e = sb[0];
               chk("l2_write", l2_write, e.wr);
               chk("l2_read", l2_read, !e.wr);
               chk("l2_address", l2_address, e.addr);
               if (e.wr) chk("l2_wdata", l2_wdata, e.wdata);
               req_cycles++;
            end
         end
         if (i_resp || d_resp) begin
            if (sb.size() == 0) begin
               chk("spurious_resp", {i_resp, d_resp}, 2'b00);
            end else begin
               e = sb.pop_front();
               chk("resp_side", {i_resp, d_resp}, e.d ? 2'b01 : 2'b10);
               chk("rdata", e.d ? d_rdata : i_rdata, e.rdata);
               chk("l2_idle_at_resp", {l2_read, l2_write}, 2'b00);
               chk("grant_cycles", req_cycles, e.lat);
            end
            req_cycles = 0;
         end
         prev_resp = i_resp || d_resp;
      end
   end

   task automatic push(input bit d, input bit wr, input logic [31:0] addr,
                       input logic [255:0] wdata, input logic [255:0] line, input int lat);
      exp_t e;
      e.d = d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = line; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_resp();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(i_resp || d_resp) && n < 100);
      chk("resp_seen", i_resp | d_resp, 1'b1);
   endtask

   task automatic txn(input bit side_d, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wdata, input int lat, input logic [255:0] line,
                      input bit change_addr);
      l2_lat = lat;
      l2_line = line;
      push(side_d, side_d && wr, addr, wdata, line, lat);
      @(negedge clk);
      if (side_d) begin
         d_read = rd; d_write = wr; d_address = addr; d_wdata = wdata;
      end else begin
         i_read = 1'b1; i_address = addr;
      end
      @(posedge clk); #1;
      chk("req_at_t_plus_1", {l2_read, l2_write}, (side_d && wr) ? 2'b01 : 2'b10);
      if (change_addr) begin
         @(negedge clk);
         i_address = 32'hDEAD_BEE0;
         d_address = 32'hDEAD_BEE0;
      end
      wait_resp();
      @(negedge clk);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
   endtask

   // Both caches request at once; each drops its request after its own response
   task automatic tie_round(input logic [31:0] ia, input logic [31:0] da);
      l2_lat = 2;
      l2_line = {8{ia ^ da}};
`ifdef L2_ARB_RR_EN
      push(1'b0, 1'b0, ia, 256'h0, l2_line, 2);
      push(1'b1, 1'b0, da, 256'h0, l2_line, 2);
`else
      push(1'b1, 1'b0, da, 256'h0, l2_line, 2);
      push(1'b0, 1'b0, ia, 256'h0, l2_line, 2);
`endif
      @(negedge clk);
      i_read = 1'b1; i_address = ia;
      d_read = 1'b1; d_address = da;
      for (int k = 0; k < 2; k++) begin
         wait_resp();
         @(negedge clk);
         if (i_resp) i_read = 1'b0;
         if (d_resp) d_read = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_resp", {i_resp, d_resp}, 2'b00);
      chk("rst_l2_req", {l2_read, l2_write}, 2'b00);
      chk("rst_l2_address", l2_address, 32'h0);
      chk("rst_l2_wdata", l2_wdata, 256'h0);
      chk("rst_rdata", i_rdata, 256'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      txn(1'b0, 1'b1, 1'b0, 32'h0000_1000, 256'h0, 5, {32{8'hA5}}, 1'b0);
      txn(1'b1, 1'b0, 1'b1, 32'h8000_0040, {8{32'h1234_5678}}, 3, {32{8'h3C}}, 1'b0);
      txn(1'b0, 1'b1, 1'b0, 32'h0000_2000, 256'h0, 4, {16{16'hBEEF}}, 1'b1);
      txn(1'b1, 1'b1, 1'b1, 32'h4000_0080, {8{32'hCAFE_F00D}}, 2, {32{8'h5A}}, 1'b0);
      txn(1'b1, 1'b1, 1'b0, 32'h0000_3000, 256'h0, 1, {8{32'h0F0F_1234}}, 1'b1);

      do_reset();
      tie_round(32'h0000_0100, 32'h0000_0200);
      tie_round(32'h0000_0300, 32'h0000_0400);

      // Reset asserted mid-transaction while a writeback is granted
      l2_lat = 20;
      push(1'b1, 1'b1, 32'h0000_7000, {8{32'h7777_0000}}, 256'h0, 20);
      @(negedge clk);
      d_write = 1'b1; d_address = 32'h0000_7000; d_wdata = {8{32'h7777_0000}};
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("async_rst_l2_write", l2_write, 1'b0);
      chk("async_rst_d_resp", d_resp, 1'b0);
      chk("async_rst_l2_address", l2_address, 32'h0);
      @(negedge clk);
      d_write = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_quiet", {i_resp, d_resp, l2_read, l2_write}, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
